// File: rtl/mips_cpu_writeback_arbiter_if.sv
// Write-back request/grant bundle between the execute/memory units and the arbiter.
//   req_valid : per-requester write pending (0 = ALU, 1 = load, 2 = mul/div)
//   req_reg   : per-requester destination, bits [5i+4:5i]
//   req_data  : per-requester write data, bits [DATA_W*i +: DATA_W]
//   grant     : one-hot or zero, combinational, driven by the arbiter
// Modports: master = requester side, slave = arbiter side.
interface mips_cpu_writeback_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 32
) ();
    logic [N_REQ-1:0]        req_valid;
    logic [5*N_REQ-1:0]      req_reg;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        grant;

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        input  grant
    );

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        output grant
    );
endinterface

// File: rtl/mips_cpu_writeback_arbiter.sv
// Shares the register file's single write port between N_REQ write-back sources and keeps a
// 32-entry scoreboard of pending long-latency destinations for read-after-write stalls.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   wb (slave)       : request/grant bundle (req_valid, req_reg, req_data, grant)
//   reserve_valid/reg: issue stage reserves a destination for a long-latency op
//   query_reg1/2     : issue-stage source operands; hazard1/2 = busy[query_regN]
//   busy_mask        : scoreboard state
//   write_enable/reg/data : registered register-file write port
//
// Configuration: define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed
// priority, lowest index first, and no pointer register is built.
module mips_cpu_writeback_arbiter #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_cpu_writeback_arbiter_if.slave wb,
    input  logic                       reserve_valid,
    input  logic [4:0]                 reserve_reg,
    input  logic [4:0]                 query_reg1,
    input  logic [4:0]                 query_reg2,
    output logic                       hazard1,
    output logic                       hazard2,
    output logic [31:0]                busy_mask,
    output logic                       write_enable,
    output logic [4:0]                 write_reg,
    output logic [DATA_W-1:0]          write_data
);

    logic [N_REQ-1:0]  pick;
    logic [N_REQ-1:0]  grant;
    logic              accept;
    logic [4:0]        sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic              we_q, we_d;
    logic [4:0]        wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [31:0]       busy_q, busy_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] req_hi;

    // Requesters at or above the pointer take precedence; if none, wrap to the lowest index.
    always_comb begin
        req_hi = wb.req_valid & ({N_REQ{1'b1}} << ptr_q);
        pick   = (req_hi != '0) ? req_hi : wb.req_valid;
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                ptr_d = (i == int'(N_REQ) - 1) ? '0 : PtrW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        pick = wb.req_valid;
    end
`endif

    // Isolate the lowest set bit of the candidate set.
    always_comb begin
        grant = reset ? '0 : (pick & (~pick + N_REQ'(1)));
    end

    assign wb.grant = grant;
    assign accept   = |grant;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                sel_reg  = wb.req_reg[5*i +: 5];
                sel_data = wb.req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Writes to r0 still commit address/data but never enable the register file.
    always_comb begin
        we_d      = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            we_d      = (sel_reg != 5'd0);
            wr_reg_d  = sel_reg;
            wr_data_d = sel_data;
        end
    end

    // Reserve is applied after the clear so a same-cycle reserve of the committed register wins.
    always_comb begin
        busy_d = busy_q;
        if (accept) begin
            busy_d[sel_reg] = 1'b0;
        end
        if (reserve_valid) begin
            busy_d[reserve_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q      <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            we_q      <= we_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign write_enable = we_q;
    assign write_reg    = wr_reg_q;
    assign write_data   = wr_data_q;
    assign busy_mask    = busy_q;
    assign hazard1      = busy_q[query_reg1];
    assign hazard2      = busy_q[query_reg2];

endmodule

// File: tb/tb_mips_cpu_writeback_arbiter.sv
module tb_mips_cpu_writeback_arbiter;
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              reserve_valid;
    logic [4:0]        reserve_reg;
    logic [4:0]        query_reg1;
    logic [4:0]        query_reg2;
    logic              hazard1;
    logic              hazard2;
    logic [31:0]       busy_mask;
    logic              write_enable;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;

    int n_checks = 0;
    int n_pass   = 0;

    mips_cpu_writeback_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) wb ();

    mips_cpu_writeback_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb           (wb.slave),
        .reserve_valid(reserve_valid),
        .reserve_reg  (reserve_reg),
        .query_reg1   (query_reg1),
        .query_reg2   (query_reg2),
        .hazard1      (hazard1),
        .hazard2      (hazard2),
        .busy_mask    (busy_mask),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        wb.req_reg[5*i +: 5]          = r;
        wb.req_data[DATA_W*i +: DATA_W] = d;
    endtask

    logic [2:0] exp_rr [6];
    logic [4:0] exp_reg [6];

    initial begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_rr  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_reg = '{5'd10, 5'd11, 5'd12, 5'd10, 5'd11, 5'd12};
`else
        exp_rr  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        exp_reg = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 5'd10};
`endif
        // Reset held two cycles with every request and a reserve active.
        reset         = 1'b1;
        wb.req_valid  = 3'b111;
        set_req(0, 5'd5, 32'h1);
        set_req(1, 5'd5, 32'h2);
        set_req(2, 5'd5, 32'h3);
        reserve_valid = 1'b1;
        reserve_reg   = 5'd5;
        query_reg1    = 5'd5;
        query_reg2    = 5'd0;
        tick();
        tick();
        check("reset_grant", 64'(wb.grant), 64'h0);
        check("reset_we", 64'(write_enable), 64'h0);
        check("reset_wreg", 64'(write_reg), 64'h0);
        check("reset_wdata", 64'(write_data), 64'h0);
        check("reset_busy", 64'(busy_mask), 64'h0);
        reset         = 1'b0;
        reserve_valid = 1'b0;

        // Single ALU write.
        wb.req_valid = 3'b001;
        set_req(0, 5'd3, 32'h1234);
        #1;
        check("single_grant", 64'(wb.grant), 64'h1);
        tick();
        check("single_we", 64'(write_enable), 64'h1);
        check("single_wreg", 64'(write_reg), 64'd3);
        check("single_wdata", 64'(write_data), 64'h1234);
        wb.req_valid = 3'b000;
        #1;
        check("idle_grant", 64'(wb.grant), 64'h0);
        tick();
        check("idle_we", 64'(write_enable), 64'h0);
        check("idle_hold_wreg", 64'(write_reg), 64'd3);
        check("idle_hold_wdata", 64'(write_data), 64'h1234);

        // Reset pulse returns the pointer to 0, then all three requesters stay valid.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 5'd10, 32'hA0);
        set_req(1, 5'd11, 32'hA1);
        set_req(2, 5'd12, 32'hA2);
        wb.req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("all_grant_%0d", c), 64'(wb.grant), 64'(exp_rr[c]));
            tick();
            check($sformatf("all_wreg_%0d", c), 64'(write_reg), 64'(exp_reg[c]));
        end
        wb.req_valid = 3'b000;

        // Write to r0: granted, never enabled.
        wb.req_valid = 3'b001;
        set_req(0, 5'd0, 32'hDEAD);
        #1;
        check("r0_grant", 64'(wb.grant), 64'h1);
        tick();
        check("r0_we", 64'(write_enable), 64'h0);
        check("r0_wreg", 64'(write_reg), 64'd0);
        check("r0_wdata", 64'(write_data), 64'hDEAD);
        wb.req_valid = 3'b000;

        // Scoreboard: reserve r8, then the load unit commits it.
        reserve_valid = 1'b1;
        reserve_reg   = 5'd8;
        query_reg1    = 5'd8;
        query_reg2    = 5'd0;
        #1;
        check("sb_hazard_before", 64'(hazard1), 64'h0);
        tick();
        reserve_valid = 1'b0;
        check("sb_hazard_set", 64'(hazard1), 64'h1);
        check("sb_busy8", 64'(busy_mask), 64'h100);
        check("sb_hazard2_r0", 64'(hazard2), 64'h0);
        tick();
        check("sb_hazard_hold", 64'(hazard1), 64'h1);
        wb.req_valid = 3'b010;
        set_req(1, 5'd8, 32'h88);
        #1;
        check("sb_load_grant", 64'(wb.grant), 64'h2);
        check("sb_hazard_in_grant", 64'(hazard1), 64'h1);
        tick();
        wb.req_valid = 3'b000;
        check("sb_hazard_clear", 64'(hazard1), 64'h0);
        check("sb_we", 64'(write_enable), 64'h1);
        check("sb_wreg", 64'(write_reg), 64'd8);
        check("sb_wdata", 64'(write_data), 64'h88);

        // Same-cycle reserve and commit of r9: reserve wins.
        reserve_valid = 1'b1;
        reserve_reg   = 5'd9;
        query_reg2    = 5'd9;
        tick();
        check("rc_hazard2_set", 64'(hazard2), 64'h1);
        wb.req_valid = 3'b100;
        set_req(2, 5'd9, 32'h99);
        #1;
        check("rc_grant", 64'(wb.grant), 64'h4);
        tick();
        reserve_valid = 1'b0;
        check("rc_busy_kept", 64'(busy_mask), 64'h200);
        check("rc_first_wreg", 64'(write_reg), 64'd9);
        tick();
        wb.req_valid = 3'b000;
        check("rc_busy_cleared", 64'(busy_mask), 64'h0);
        check("rc_hazard2_clear", 64'(hazard2), 64'h0);

        // Reserving r0 is ignored; reset mid-operation drops scoreboard state.
        reserve_valid = 1'b1;
        reserve_reg   = 5'd0;
        tick();
        check("r0_reserve_ignored", 64'(busy_mask), 64'h0);
        reserve_reg = 5'd7;
        tick();
        reserve_valid = 1'b0;
        check("r7_reserved", 64'(busy_mask), 64'h80);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", 64'(busy_mask), 64'h0);
        check("midreset_we", 64'(write_enable), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
